// File: rtl/dma_to_finn_fifo.sv
// Adapter from the AXI DMA MM2S stream to the FINN stitched-IP input: truncating
// first-word-fall-through FIFO plus a TLAST framing checker with sticky error flags.
module dma_to_finn_fifo #(
  parameter int DEPTH          = 8,
  parameter int IN_DATA_WIDTH  = 32,
  parameter int OUT_DATA_WIDTH = 8,
  parameter int FRAME_LEN      = 16,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_axis_tvalid,
  input  logic [IN_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  output logic                       m_axis_tvalid,
  output logic [OUT_DATA_WIDTH-1:0]  m_axis_tdata,
  input  logic                       m_axis_tready,
  input  logic                       err_clr,
  output logic                       err_tlast_early,
  output logic                       err_tlast_missing,
  output logic                       err_upper_nz,
  output logic [CNT_WIDTH-1:0]       frame_cnt,
  output logic [$clog2(DEPTH):0]     fill_level
);

  localparam int PTR_WIDTH  = $clog2(DEPTH);
  localparam int BEAT_WIDTH = $clog2(FRAME_LEN);
  localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(FRAME_LEN - 1);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] IN_FRAME = 1'b1;

  logic [OUT_DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH:0]        wr_ptr;
  logic [PTR_WIDTH:0]        rd_ptr;
  logic                      full;
  logic                      empty;
  logic                      accept;
  logic                      pop;
  logic                      upper_nz;
  logic [0:0]                state;
  logic [BEAT_WIDTH-1:0]     beat_cnt;
  logic                      set_early;
  logic                      set_missing;
  logic                      frame_done;

  assign empty         = (wr_ptr == rd_ptr);
  assign full          = (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]) &&
                         (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]);
  assign s_axis_tready = ~full;
  assign m_axis_tvalid = ~empty;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign pop           = m_axis_tvalid & m_axis_tready;
  assign m_axis_tdata  = mem[rd_ptr[PTR_WIDTH-1:0]];
  assign fill_level    = wr_ptr - rd_ptr;

  generate
    if (IN_DATA_WIDTH > OUT_DATA_WIDTH) begin : g_upper
      assign upper_nz = |s_axis_tdata[IN_DATA_WIDTH-1:OUT_DATA_WIDTH];
    end else begin : g_no_upper
      assign upper_nz = 1'b0;
    end
  endgenerate

  // Storage has no reset; stale entries are never visible because valid comes from the pointers.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr[PTR_WIDTH-1:0]] <= s_axis_tdata[OUT_DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_comb begin
    set_early   = 1'b0;
    set_missing = 1'b0;
    frame_done  = 1'b0;
    if (accept) begin
      if (state == IDLE || beat_cnt != LAST_BEAT) begin
        set_early = s_axis_tlast;
      end else begin
        frame_done  = s_axis_tlast;
        set_missing = ~s_axis_tlast;
      end
    end
  end

  // Any TLAST or the final beat position closes the frame, so a missing TLAST resyncs on FRAME_LEN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      frame_cnt <= '0;
    end else if (accept) begin
      if (s_axis_tlast || beat_cnt == LAST_BEAT) begin
        state    <= IDLE;
        beat_cnt <= '0;
      end else begin
        state    <= IN_FRAME;
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (frame_done) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_tlast_early   <= 1'b0;
      err_tlast_missing <= 1'b0;
      err_upper_nz      <= 1'b0;
    end else begin
      if (err_clr) begin
        err_tlast_early   <= 1'b0;
        err_tlast_missing <= 1'b0;
        err_upper_nz      <= 1'b0;
      end
      if (set_early)          err_tlast_early   <= 1'b1;
      if (set_missing)        err_tlast_missing <= 1'b1;
      if (accept && upper_nz) err_upper_nz      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dma_to_finn_fifo.sv
// Self-checking bench for dma_to_finn_fifo: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_dma_to_finn_fifo;

  localparam int DEPTH     = 8;
  localparam int IN_W      = 32;
  localparam int OUT_W     = 8;
  localparam int FRAME_LEN = 16;
  localparam int CNT_W     = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               s_axis_tvalid = 1'b0;
  logic [IN_W-1:0]    s_axis_tdata = '0;
  logic               s_axis_tlast = 1'b0;
  logic               s_axis_tready;
  logic               m_axis_tvalid;
  logic [OUT_W-1:0]   m_axis_tdata;
  logic               m_axis_tready = 1'b0;
  logic               err_clr = 1'b0;
  logic               err_tlast_early;
  logic               err_tlast_missing;
  logic               err_upper_nz;
  logic [CNT_W-1:0]   frame_cnt;
  logic [$clog2(DEPTH):0] fill_level;

  always #5 clk = ~clk;

  dma_to_finn_fifo #(
    .DEPTH(DEPTH), .IN_DATA_WIDTH(IN_W), .OUT_DATA_WIDTH(OUT_W),
    .FRAME_LEN(FRAME_LEN), .CNT_WIDTH(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tready(m_axis_tready), .err_clr(err_clr),
    .err_tlast_early(err_tlast_early), .err_tlast_missing(err_tlast_missing),
    .err_upper_nz(err_upper_nz), .frame_cnt(frame_cnt), .fill_level(fill_level)
  );

  int tests_run = 0;
  int tests_failed = 0;
  bit rand_ready = 0;

  logic [7:0] mq[$];
  logic [7:0] captured[$];
  int         m_beat = 0;
  logic       m_early = 1'b0;
  logic       m_missing = 1'b0;
  logic       m_upper = 1'b0;
  logic [CNT_W-1:0] m_frames = '0;
  bit         m_acc;
  bit         m_pop;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: a byte queue bounded at DEPTH plus a frame position counter.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_beat    = 0;
      m_early   = 1'b0;
      m_missing = 1'b0;
      m_upper   = 1'b0;
      m_frames  = '0;
    end else begin
      m_acc = s_axis_tvalid && (mq.size() < DEPTH);
      m_pop = m_axis_tready && (mq.size() > 0);
      if (m_pop) void'(mq.pop_front());
      if (err_clr) begin
        m_early = 1'b0; m_missing = 1'b0; m_upper = 1'b0;
      end
      if (m_acc) begin
        mq.push_back(s_axis_tdata[7:0]);
        if (s_axis_tdata[31:8] != 24'h0) m_upper = 1'b1;
        if (s_axis_tlast) begin
          if (m_beat == FRAME_LEN - 1) m_frames = m_frames + 1'b1;
          else m_early = 1'b1;
          m_beat = 0;
        end else if (m_beat == FRAME_LEN - 1) begin
          m_missing = 1'b1;
          m_beat = 0;
        end else begin
          m_beat++;
        end
      end
    end
  end

  always @(negedge clk) begin
    check_output("s_tready", 32'(s_axis_tready), 32'(mq.size() < DEPTH));
    check_output("m_tvalid", 32'(m_axis_tvalid), 32'(mq.size() != 0));
    if (mq.size() != 0) check_output("m_tdata", 32'(m_axis_tdata), 32'(mq[0]));
    check_output("fill_level", 32'(fill_level), 32'(mq.size()));
    check_output("frame_cnt", 32'(frame_cnt), 32'(m_frames));
    check_output("err_early", 32'(err_tlast_early), 32'(m_early));
    check_output("err_missing", 32'(err_tlast_missing), 32'(m_missing));
    check_output("err_upper", 32'(err_upper_nz), 32'(m_upper));
    if (m_axis_tvalid && m_axis_tready) captured.push_back(m_axis_tdata);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] data, input logic last);
    int  waited = 0;
    logic took;
    if (rand_ready) begin
      while ($urandom_range(0, 3) == 0) begin
        s_axis_tvalid = 1'b0;
        m_axis_tready = ($urandom_range(0, 3) != 0);
        step();
      end
    end
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = data;
    s_axis_tlast  = last;
    forever begin
      if (rand_ready) m_axis_tready = ($urandom_range(0, 3) != 0);
      took = s_axis_tready;
      step();
      if (took) break;
      waited++;
      if (waited > 1000) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL send_timeout: beat 0x%0h never accepted", data);
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    m_axis_tready = 1'b1;
    while (mq.size() != 0 && waited < 100) begin
      step();
      waited++;
    end
    tests_run++;
    if (mq.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL drain_timeout: %0d entries left, expected 0", mq.size());
    end
    step();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (3) step();
    check_output("rst_fill", 32'(fill_level), 32'd0);
    check_output("rst_mvalid", 32'(m_axis_tvalid), 32'd0);
    check_output("rst_sready", 32'(s_axis_tready), 32'd1);
    check_output("rst_frames", 32'(frame_cnt), 32'd0);
    rst_n = 1'b1;
    step();

    // 1: one clean frame, model consumes freely
    m_axis_tready = 1'b1;
    captured.delete();
    for (int i = 0; i < 16; i++) send_beat(32'(i), i == 15);
    drain();
    check_output("t1_count", 32'(captured.size()), 32'd16);
    for (int i = 0; i < 16 && i < captured.size(); i++)
      check_output("t1_data", 32'(captured[i]), 32'(i));
    check_output("t1_frames", 32'(frame_cnt), 32'd1);
    check_output("t1_err", 32'({err_tlast_early, err_tlast_missing, err_upper_nz}), 32'd0);

    // 2: backpressure fills the FIFO; a pop while full frees the slot only next cycle
    m_axis_tready = 1'b0;
    captured.delete();
    for (int i = 0; i < 8; i++) send_beat(32'h30 + 32'(i), 1'b0);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'h38;
    s_axis_tlast  = 1'b0;
    step();
    check_output("t2_full_sready", 32'(s_axis_tready), 32'd0);
    check_output("t2_full_fill", 32'(fill_level), 32'd8);
    m_axis_tready = 1'b1;
    check_output("t2_pop_sready", 32'(s_axis_tready), 32'd0);
    step();
    check_output("t2_after_pop_fill", 32'(fill_level), 32'd7);
    check_output("t2_after_pop_sready", 32'(s_axis_tready), 32'd1);
    step();
    s_axis_tvalid = 1'b0;
    check_output("t2_accept_fill", 32'(fill_level), 32'd7);
    for (int i = 9; i < 16; i++) send_beat(32'h30 + 32'(i), i == 15);
    drain();
    check_output("t2_count", 32'(captured.size()), 32'd16);
    for (int i = 0; i < 16 && i < captured.size(); i++)
      check_output("t2_data", 32'(captured[i]), 32'h30 + 32'(i));
    check_output("t2_frames", 32'(frame_cnt), 32'd2);

    // 3: random handshakes over 1000 frames
    rand_ready = 1;
    for (int f = 0; f < 1000; f++)
      for (int b = 0; b < 16; b++)
        send_beat(32'($urandom_range(0, 255)), b == 15);
    rand_ready = 0;
    drain();
    check_output("t3_frames", 32'(frame_cnt), 32'd1002);
    check_output("t3_fill", 32'(fill_level), 32'd0);

    // 4: early TLAST, then a frame with no TLAST, then clear
    for (int i = 0; i < 6; i++) send_beat(32'h40 + 32'(i), i == 5);
    check_output("t4_early", 32'(err_tlast_early), 32'd1);
    for (int i = 0; i < 15; i++) send_beat(32'h50 + 32'(i), 1'b0);
    check_output("t4_not_missing_yet", 32'(err_tlast_missing), 32'd0);
    send_beat(32'h5F, 1'b0);
    check_output("t4_missing", 32'(err_tlast_missing), 32'd1);
    check_output("t4_frames", 32'(frame_cnt), 32'd1002);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check_output("t4_clr", 32'({err_tlast_early, err_tlast_missing}), 32'd0);
    drain();

    // 5: non-zero discarded upper bits
    captured.delete();
    send_beat(32'hA500_0012, 1'b0);
    drain();
    check_output("t5_byte", 32'(captured.size() > 0 ? captured[0] : 8'h00), 32'h12);
    check_output("t5_upper", 32'(err_upper_nz), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check_output("t5_clr", 32'(err_upper_nz), 32'd0);
    for (int i = 1; i < 16; i++) send_beat(32'(i), i == 15);
    drain();
    check_output("t5_frames", 32'(frame_cnt), 32'd1003);

    // 6: reset mid-frame with data stored
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) send_beat(32'h60 + 32'(i), 1'b0);
    check_output("t6_fill", 32'(fill_level), 32'd5);
    rst_n = 1'b0;
    #1;
    check_output("t6_rst_fill", 32'(fill_level), 32'd0);
    check_output("t6_rst_mvalid", 32'(m_axis_tvalid), 32'd0);
    check_output("t6_rst_frames", 32'(frame_cnt), 32'd0);
    check_output("t6_rst_sready", 32'(s_axis_tready), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 16; i++) send_beat(32'h70 + 32'(i), i == 15);
    drain();
    check_output("t6_frames", 32'(frame_cnt), 32'd1);
    check_output("t6_err", 32'({err_tlast_early, err_tlast_missing, err_upper_nz}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
